memory_access_rv32: RTL and testbench

Load/store memory-access stage for the RV32 core. It accepts one load or store from the execute stage and drives a single request to the data-memory bus. For loads, it waits for the response and right-aligns the returned word by the address byte offset. It hands the aligned word and the width/sign controls to the downstream load sign/zero-extension stage through a valid/ready handshake.

---
 rtl/memory_access_rv32.sv | 170 +++++++++++++++++
 tb/tb_memory_access_rv32.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_rv32.sv
// RV32 load/store memory-access stage: one bus request per access,
// load data right-aligned by byte offset, result handed downstream.
module memory_access_rv32 #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_LEN-1:0] in_addr,
  input  logic [DATA_LEN-1:0] in_wdata,
  input  logic                in_is_load,
  input  logic                in_is_store,
  input  logic                in_is_byte,
  input  logic                in_is_half,
  input  logic                in_is_word,
  input  logic                in_is_sign,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_LEN-1:0] mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_LEN-1:0] mem_req_wdata,
  output logic [3:0]          mem_req_wstrb,
  input  logic                mem_resp_valid,
  input  logic [DATA_LEN-1:0] mem_resp_data,
  input  logic                mem_resp_err,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_pre_data,
  output logic                out_is_load,
  output logic                out_is_byte,
  output logic                out_is_half,
  output logic                out_is_word,
  output logic                out_is_sign,
  output logic                out_misalign,
  output logic                out_bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_q;
  logic [ADDR_LEN-1:0] addr_q;
  logic [DATA_LEN-1:0] wdata_q;
  logic [DATA_LEN-1:0] pre_q;
  logic [3:0]          wstrb_q;
  logic                wen_q;
  logic                load_q;
  logic                byte_q;
  logic                half_q;
  logic                word_q;
  logic                sign_q;
  logic                mis_q;
  logic                err_q;

  logic [1:0]          off;
  logic                sel_byte;
  logic                sel_half;
  logic                sel_word;
  logic                fault;
  logic                wen_d;
  logic [DATA_LEN-1:0] wdata_d;
  logic [3:0]          wstrb_d;

  assign off = in_addr[1:0];

  // Width priority byte > half > word when several bits are set.
  assign sel_byte = in_is_byte;
  assign sel_half = !in_is_byte && in_is_half;
  assign sel_word = !in_is_byte && !in_is_half && in_is_word;

  assign fault = !(in_is_load || in_is_store)
              || !(sel_byte || sel_half || sel_word)
              || (sel_half && off[0])
              || (sel_word && (off != 2'b00));

  assign wen_d = in_is_store && !in_is_load;

  always_comb begin
    wdata_d = in_wdata;
    wstrb_d = 4'b1111;
    unique case (1'b1)
      sel_byte: begin
        wdata_d = {4{in_wdata[7:0]}};
        wstrb_d = 4'b0001 << off;
      end
      sel_half: begin
        wdata_d = {2{in_wdata[15:0]}};
        wstrb_d = 4'b0011 << off;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      pre_q   <= '0;
      wstrb_q <= '0;
      wen_q   <= 1'b0;
      load_q  <= 1'b0;
      byte_q  <= 1'b0;
      half_q  <= 1'b0;
      word_q  <= 1'b0;
      sign_q  <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          addr_q  <= in_addr;
          wdata_q <= wdata_d;
          wstrb_q <= wen_d ? wstrb_d : 4'b0000;
          wen_q   <= wen_d;
          load_q  <= in_is_load;
          byte_q  <= in_is_byte;
          half_q  <= in_is_half;
          word_q  <= in_is_word;
          sign_q  <= in_is_sign;
          pre_q   <= '0;
          mis_q   <= fault;
          err_q   <= 1'b0;
          state_q <= fault ? DONE : REQ;
        end
        REQ: if (mem_req_ready) begin
          state_q <= WAIT;
        end
        WAIT: if (mem_resp_valid) begin
          err_q   <= mem_resp_err;
          pre_q   <= (load_q && !mem_resp_err)
                   ? mem_resp_data >> {addr_q[1:0], 3'b000}
                   : '0;
          state_q <= DONE;
        end
        DONE: if (out_ready) begin
          mis_q   <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign mem_req_valid = (state_q == REQ);
  assign out_valid     = (state_q == DONE);

  assign mem_req_addr  = {addr_q[ADDR_LEN-1:2], 2'b00};
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wstrb = wstrb_q;

  assign out_pre_data  = pre_q;
  assign out_is_load   = load_q;
  assign out_is_byte   = byte_q;
  assign out_is_half   = half_q;
  assign out_is_word   = word_q;
  assign out_is_sign   = sign_q;
  assign out_misalign  = mis_q;
  assign out_bus_err   = err_q;

endmodule

// File: tb/tb_memory_access_rv32.sv
// Scoreboard bench for memory_access_rv32: randomized accesses,
// reference model, bus responder, request and result monitors.
module tb_memory_access_rv32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        in_is_load;
  logic        in_is_store;
  logic        in_is_byte;
  logic        in_is_half;
  logic        in_is_word;
  logic        in_is_sign;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pre_data;
  logic        out_is_load;
  logic        out_is_byte;
  logic        out_is_half;
  logic        out_is_word;
  logic        out_is_sign;
  logic        out_misalign;
  logic        out_bus_err;

  memory_access_rv32 #(.DATA_LEN(32), .ADDR_LEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_wdata(in_wdata),
    .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_is_byte(in_is_byte), .in_is_half(in_is_half),
    .in_is_word(in_is_word), .in_is_sign(in_is_sign),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .mem_resp_err(mem_resp_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pre_data(out_pre_data), .out_is_load(out_is_load),
    .out_is_byte(out_is_byte), .out_is_half(out_is_half),
    .out_is_word(out_is_word), .out_is_sign(out_is_sign),
    .out_misalign(out_misalign), .out_bus_err(out_bus_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit ld, st, b, h, w, sg, err, stray;
    int req_wait;
    int resp_wait;
  } txn_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct {
    logic [31:0] pre;
    logic [6:0]  flags;
    int          at;
  } out_t;

  typedef struct {
    int          req_wait;
    int          resp_wait;
    logic [31:0] rdata;
    bit          err;
    bit          stray;
  } plan_t;

  req_t  req_q[$];
  out_t  out_q[$];
  plan_t plan_q[$];

  int n_chk = 0;
  int n_pass = 0;
  bit busy = 1'b0;
  bit rsp_busy = 1'b0;
  int sink_lag = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h t=%0t",
                  nm, act, exp, $time);
  endtask

  task automatic finish_run();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  endtask

  function automatic txn_t mk(input logic [31:0] a,
                              input logic [31:0] wd,
                              input logic [31:0] rd,
                              input bit ld, input bit st,
                              input bit b, input bit h,
                              input bit w, input bit sg);
    txn_t t;
    t.addr = a; t.wdata = wd; t.rdata = rd;
    t.ld = ld; t.st = st; t.b = b; t.h = h; t.w = w;
    t.sg = sg; t.err = 0; t.stray = 0;
    t.req_wait = 0; t.resp_wait = 0;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    int k;
    logic [2:0] wb;
    t = mk(32'h8000_0000 | ($urandom & 32'h0000_FFFF),
           $urandom, $urandom, 0, 0, 0, 0, 0, 0);
    k = int'($urandom % 20);
    t.ld = (k != 0) && k[0];
    t.st = (k != 0) && !k[0];
    k = int'($urandom % 16);
    if (k == 0) wb = 3'b000;
    else if (k < 3) wb = 3'($urandom % 8);
    else wb = 3'b001 << ($urandom % 3);
    t.b = wb[0]; t.h = wb[1]; t.w = wb[2];
    t.sg = ($urandom % 2) == 1;
    t.err = ($urandom % 8) == 0;
    t.stray = ($urandom % 4) == 0;
    t.req_wait = int'($urandom % 4);
    t.resp_wait = int'($urandom % 4);
    return t;
  endfunction

  // Access size in bytes after width priority; 0 means no width.
  function automatic int size_of(input txn_t t);
    if (t.b) return 1;
    if (t.h) return 2;
    if (t.w) return 4;
    return 0;
  endfunction

  function automatic bit faulty(input txn_t t);
    int sz;
    sz = size_of(t);
    if (!t.ld && !t.st) return 1;
    if (sz == 0) return 1;
    return (t.addr % sz) != 0;
  endfunction

  function automatic logic [31:0] lanes(input txn_t t);
    int sz;
    logic [31:0] mask;
    logic [31:0] r;
    sz = size_of(t);
    mask = (sz == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * sz)) - 1;
    r = 0;
    for (int k = 0; k < 4; k += sz)
      r = r | ((t.wdata & mask) << (8 * k));
    return r;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy || rsp_busy) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        check("idle_timeout", 32'd1, 32'd0);
        finish_run();
      end
    end
  endtask

  task automatic issue(input txn_t t, input int lag);
    bit   f;
    int   sz;
    int   off;
    req_t r;
    out_t o;
    plan_t p;
    wait_idle();
    @(posedge clk); #1;
    f = faulty(t);
    sz = size_of(t);
    off = int'(t.addr % 4);
    sink_lag = lag;
    if (!f) begin
      p.req_wait = t.req_wait; p.resp_wait = t.resp_wait;
      p.rdata = t.rdata; p.err = t.err; p.stray = t.stray;
      plan_q.push_back(p);
    end
    in_valid = 1; in_addr = t.addr; in_wdata = t.wdata;
    in_is_load = t.ld; in_is_store = t.st;
    in_is_byte = t.b; in_is_half = t.h;
    in_is_word = t.w; in_is_sign = t.sg;
    @(posedge clk); #1;
    in_valid = 0;
    in_addr = $urandom; in_wdata = $urandom;
    in_is_sign = ~in_is_sign;
    busy = 1;
    if (!f) begin
      r.addr = t.addr & 32'hFFFF_FFFC;
      r.wen = t.st;
      r.wdata = lanes(t);
      r.wstrb = t.st ? 4'(((1 << sz) - 1) << off) : 4'b0000;
      req_q.push_back(r);
    end
    if (f || t.err || !t.ld) o.pre = 0;
    else o.pre = t.rdata >> (8 * off);
    o.flags = {t.ld, t.b, t.h, t.w, t.sg, f, !f && t.err};
    o.at = f ? cyc : cyc + t.req_wait + t.resp_wait + 2;
    out_q.push_back(o);
  endtask

  // Bus responder: follows one plan per request.
  initial begin
    plan_t p;
    mem_req_ready = 0; mem_resp_valid = 0;
    mem_resp_data = 0; mem_resp_err = 0;
    forever begin
      @(posedge clk); #1;
      mem_resp_valid = ($urandom % 8) == 0;
      mem_resp_err = 1;
      mem_resp_data = $urandom;
      if (mem_req_valid && plan_q.size() > 0) begin
        p = plan_q.pop_front();
        rsp_busy = 1;
        repeat (p.req_wait) begin @(posedge clk); #1; end
        mem_req_ready = 1;
        mem_resp_valid = p.stray;
        @(posedge clk); #1;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_err = 0;
        repeat (p.resp_wait) begin @(posedge clk); #1; end
        mem_resp_valid = 1; mem_resp_data = p.rdata;
        mem_resp_err = p.err;
        @(posedge clk); #1;
        mem_resp_valid = 0; mem_resp_err = 0;
        rsp_busy = 0;
      end
    end
  end

  // Result sink: holds out_ready low for sink_lag DONE cycles.
  initial begin
    int low;
    low = 0;
    out_ready = 0;
    forever begin
      @(posedge clk); #1;
      if (out_valid) begin
        if (low < sink_lag) begin out_ready = 0; low++; end
        else out_ready = 1;
      end else begin
        out_ready = ($urandom % 2) == 1;
        low = 0;
      end
    end
  end

  // Request monitor.
  initial begin
    req_t r;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req_valid) begin
        if (req_q.size() == 0) check("req_spurious", 32'd1, 32'd0);
        else begin
          r = req_q[0];
          check("req_addr", mem_req_addr, r.addr);
          check("req_wen", 32'(mem_req_wen), 32'(r.wen));
          check("req_wstrb", 32'(mem_req_wstrb), 32'(r.wstrb));
          if (r.wen) check("req_wdata", mem_req_wdata, r.wdata);
          if (mem_req_ready) void'(req_q.pop_front());
        end
      end
    end
  end

  // Result monitor.
  initial begin
    out_t o;
    bit seen;
    seen = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("in_ready", 32'(in_ready), 32'(!busy));
        if (out_valid) begin
          if (out_q.size() == 0) check("out_spurious", 32'd1, 32'd0);
          else begin
            o = out_q[0];
            if (!seen) begin
              check("out_latency", cyc, o.at);
              seen = 1;
            end
            check("out_pre_data", out_pre_data, o.pre);
            check("out_flags",
                  32'({out_is_load, out_is_byte, out_is_half,
                       out_is_word, out_is_sign, out_misalign,
                       out_bus_err}),
                  32'(o.flags));
            if (out_ready) begin
              void'(out_q.pop_front());
              busy = 0;
              seen = 0;
            end
          end
        end
      end else seen = 0;
    end
  end

  initial begin
    #500000;
    check("watchdog", 32'd1, 32'd0);
    finish_run();
  end

  initial begin
    txn_t t;
    in_valid = 0; in_addr = 0; in_wdata = 0;
    in_is_load = 0; in_is_store = 0; in_is_byte = 0;
    in_is_half = 0; in_is_word = 0; in_is_sign = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_pre_data", out_pre_data, 32'd0);
    check("rst_misalign", 32'(out_misalign), 32'd0);
    check("rst_bus_err", 32'(out_bus_err), 32'd0);
    rst_n = 1;

    t = mk(32'h8000_0003, 32'h0, 32'hAB12_3456, 1, 0, 1, 0, 0, 1);
    issue(t, 0);
    t = mk(32'h8000_0002, 32'h0000_BEEF, 32'h1234_5678,
           0, 1, 0, 1, 0, 0);
    issue(t, 0);
    t = mk(32'h8000_0001, 32'h0, 32'h0, 1, 0, 0, 0, 1, 0);
    issue(t, 1);
    t = mk(32'h8000_0010, 32'h0, 32'hCAFE_F00D, 1, 0, 0, 0, 1, 0);
    t.req_wait = 3; t.resp_wait = 2;
    issue(t, 2);
    t = mk(32'h8000_0020, 32'h0, 32'h5555_AAAA, 1, 0, 0, 0, 1, 0);
    t.err = 1;
    issue(t, 0);
    t = mk(32'h8000_0024, 32'h0, 32'h0BAD_F00D, 1, 0, 0, 0, 1, 0);
    issue(t, 0);

    // Abort a load in WAIT; its late response must be ignored.
    t = mk(32'h8000_0008, 32'h0, 32'hDEAD_BEEF, 1, 0, 0, 0, 1, 0);
    t.resp_wait = 6;
    issue(t, 0);
    @(posedge clk); #1;
    rst_n = 0;
    busy = 0;
    out_q.delete();
    req_q.delete();
    #1;
    check("abort_req_valid", 32'(mem_req_valid), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("abort_hold_ready", 32'(in_ready), 32'd1);
    rst_n = 1;
    wait_idle();
    t = mk(32'h8000_0004, 32'h0, 32'h1357_9BDF, 1, 0, 0, 0, 1, 0);
    issue(t, 0);

    repeat (150) begin
      t = rand_txn();
      issue(t, int'($urandom % 3));
    end
    wait_idle();
    repeat (4) @(negedge clk);
    check("req_q_drained", 32'(req_q.size()), 32'd0);
    check("out_q_drained", 32'(out_q.size()), 32'd0);
    finish_run();
  end

endmodule
